// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin sequencer in front of a parity memory.
// Accepts one request at a time from client A or B and issues it to memory.
// Read data comes back one cycle after mem_read is sampled. Each word is
// {parity, data} with even parity, and the arbiter checks it before
// returning the data to the client that owns the transaction.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic                 we_a,
    input  logic                 we_b,
    input  logic [ADDR_W-1:0]    addr_a,
    input  logic [ADDR_W-1:0]    addr_b,
    input  logic [DATA_W-1:0]    wdata_a,
    input  logic [DATA_W-1:0]    wdata_b,
    output logic                 ack_a,
    output logic                 ack_b,
    output logic                 rsp_valid_a,
    output logic                 rsp_valid_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic                 perr_a,
    output logic                 perr_b,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_data_in,
    input  logic [DATA_W:0]      mem_data_out,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;   // 0 = A, 1 = B
    logic                  r_owner;        // 0 = A, 1 = B
    logic                  r_ack_a;
    logic                  r_ack_b;
    logic                  r_rsp_valid_a;
    logic                  r_rsp_valid_b;
    logic [DATA_W-1:0]     r_rdata_a;
    logic [DATA_W-1:0]     r_rdata_b;
    logic                  r_perr_a;
    logic                  r_perr_b;
    logic                  r_mem_write;
    logic                  r_mem_read;
    logic [ADDR_W-1:0]     r_mem_address;
    logic [DATA_W-1:0]     r_mem_data_in;
    logic [ERR_CNT_W-1:0]  r_err_count;

    logic                  w_any_req;
    logic                  w_pick_b;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_perr;

    // Arbitration: a lone requester wins; on a tie, the one not granted last wins
    always_comb begin
        w_any_req   = req_a | req_b;
        w_pick_b    = req_b & (~req_a | ~r_last_grant);
        w_sel_we    = w_pick_b ? we_b    : we_a;
        w_sel_addr  = w_pick_b ? addr_b  : addr_a;
        w_sel_wdata = w_pick_b ? wdata_b : wdata_a;
        // Even parity across all 9 bits: any odd count of ones is an error
        w_perr      = ^mem_data_out;
    end

    // Sequencer FSM with registered pulses, memory controls and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;          // so that A wins the first tie
            r_owner       <= 1'b0;
            r_ack_a       <= 1'b0;
            r_ack_b       <= 1'b0;
            r_rsp_valid_a <= 1'b0;
            r_rsp_valid_b <= 1'b0;
            r_rdata_a     <= '0;
            r_rdata_b     <= '0;
            r_perr_a      <= 1'b0;
            r_perr_b      <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_err_count   <= '0;
        end else begin
            // Single-cycle pulses default low; address/data/rdata hold their values
            r_ack_a       <= 1'b0;
            r_ack_b       <= 1'b0;
            r_rsp_valid_a <= 1'b0;
            r_rsp_valid_b <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_pick_b;
                        r_last_grant  <= w_pick_b;
                        r_mem_address <= w_sel_addr;
                        r_ack_a       <= ~w_pick_b;
                        r_ack_b       <= w_pick_b;
                        if (w_sel_we) begin
                            r_mem_write   <= 1'b1;
                            r_mem_data_in <= w_sel_wdata;
                            r_state       <= S_WR;
                        end else begin
                            r_mem_read    <= 1'b1;
                            r_state       <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                end
                S_RD: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Memory data is valid now; capture it for the owner
                    if (r_owner) begin
                        r_rdata_b     <= mem_data_out[DATA_W-1:0];
                        r_perr_b      <= w_perr;
                        r_rsp_valid_b <= 1'b1;
                    end else begin
                        r_rdata_a     <= mem_data_out[DATA_W-1:0];
                        r_perr_a      <= w_perr;
                        r_rsp_valid_a <= 1'b1;
                    end
                    if (w_perr && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                        r_err_count <= r_err_count + ERR_CNT_W'(1);
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_a       = r_ack_a;
    assign ack_b       = r_ack_b;
    assign rsp_valid_a = r_rsp_valid_a;
    assign rsp_valid_b = r_rsp_valid_b;
    assign rdata_a     = r_rdata_a;
    assign rdata_b     = r_rdata_b;
    assign perr_a      = r_perr_a;
    assign perr_b      = r_perr_b;
    assign mem_write   = r_mem_write;
    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign busy        = (r_state != S_IDLE);
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural parity memory, a reference model
// of round-robin arbitration and of memory contents, and one task per feature.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [15:0] addr_a = '0, addr_b = '0;
    logic [7:0]  wdata_a = '0, wdata_b = '0;
    logic        ack_a, ack_b, rsp_valid_a, rsp_valid_b, perr_a, perr_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        mem_write, mem_read, busy;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [8:0]  mem_data_out = '0;
    logic [7:0]  err_count;

    // Second instance with a 2-bit error counter, sharing all inputs
    logic        d2_ack_a, d2_ack_b, d2_rsp_valid_a, d2_rsp_valid_b, d2_perr_a, d2_perr_b;
    logic [7:0]  d2_rdata_a, d2_rdata_b;
    logic        d2_mem_write, d2_mem_read, d2_busy;
    logic [15:0] d2_mem_address;
    logic [7:0]  d2_mem_data_in;
    logic [1:0]  d2_err_count;

    int checks = 0;
    int failures = 0;
    bit model_last = 1'b1;              // 0 = A granted last, 1 = B
    logic [7:0] ref_mem [int];          // what clients have written
    bit         force_en = 1'b0;
    logic [15:0] force_addr = '0;
    logic [8:0]  force_val = '0;
    logic [8:0]  mem_model [int];       // the memory's own storage

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .perr_a(perr_a), .perr_b(perr_b),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy), .err_count(err_count)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(d2_ack_a), .ack_b(d2_ack_b), .rsp_valid_a(d2_rsp_valid_a), .rsp_valid_b(d2_rsp_valid_b),
        .rdata_a(d2_rdata_a), .rdata_b(d2_rdata_b), .perr_a(d2_perr_a), .perr_b(d2_perr_b),
        .mem_write(d2_mem_write), .mem_read(d2_mem_read), .mem_address(d2_mem_address),
        .mem_data_in(d2_mem_data_in), .mem_data_out(mem_data_out), .busy(d2_busy), .err_count(d2_err_count)
    );

    // Behavioural parity memory: stores {even parity, data}, read data valid next cycle
    always @(posedge clk) begin
        if (mem_write) mem_model[int'(mem_address)] = {^mem_data_in, mem_data_in};
        if (mem_read) begin
            if (force_en && mem_address == force_addr) mem_data_out <= force_val;
            else if (mem_model.exists(int'(mem_address))) mem_data_out <= mem_model[int'(mem_address)];
            else mem_data_out <= 9'h000;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration rule: both requesting -> the one not granted last
    function automatic bit pick_b(input bit ra, input bit rb, input bit last);
        if (ra && rb) return !last;
        return rb;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_req(input bit cl, input bit we, input logic [15:0] a, input logic [7:0] d);
        if (!cl) begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
        else     begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
    endtask

    task automatic drop_reqs;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic wait_ack(input bit cl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cl ? ack_b : ack_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rsp(input bit cl, output logic [7:0] rd, output bit pe, output bit other, output bit ok);
        ok = 1'b0; rd = '0; pe = 1'b0; other = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cl ? rsp_valid_b : rsp_valid_a) begin
                ok = 1'b1;
                rd = cl ? rdata_b : rdata_a;
                pe = cl ? perr_b : perr_a;
                other = cl ? rsp_valid_a : rsp_valid_b;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; drop_reqs();
        repeat (2) tick();
        checks++; if ({ack_a, ack_b, rsp_valid_a, rsp_valid_b, perr_a, perr_b, mem_write, mem_read, busy} !== 9'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000000", {ack_a, ack_b, rsp_valid_a, rsp_valid_b, perr_a, perr_b, mem_write, mem_read, busy}); end
        checks++; if (mem_address !== 16'h0 || mem_data_in !== 8'h0) begin
            failures++; $display("FAIL reset_mem_bus got=%h/%h want=0000/00", mem_address, mem_data_in); end
        checks++; if (rdata_a !== 8'h0 || rdata_b !== 8'h0) begin
            failures++; $display("FAIL reset_rdata got=%h/%h want=00/00", rdata_a, rdata_b); end
        checks++; if (err_count !== 8'h0 || d2_err_count !== 2'h0) begin
            failures++; $display("FAIL reset_err_count got=%0d/%0d want=0/0", err_count, d2_err_count); end
        model_last = 1'b1;
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || ack_a !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b ack_a=%b want=0/0", busy, ack_a); end
    endtask

    task automatic test_write_read;
        drive_req(1'b0, 1'b1, 16'h1234, 8'hA5);
        tick();
        checks++; if (ack_a !== 1'b1 || ack_b !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
            failures++; $display("FAIL wr_ack ack_a=%b ack_b=%b mw=%b mr=%b want=1/0/1/0", ack_a, ack_b, mem_write, mem_read); end
        checks++; if (mem_address !== 16'h1234 || mem_data_in !== 8'hA5) begin
            failures++; $display("FAIL wr_bus got=%h/%h want=1234/a5", mem_address, mem_data_in); end
        $display("txn A W addr=1234 data=a5");
        ref_mem[16'h1234] = 8'hA5; model_last = 1'b0;
        drop_reqs();
        tick();
        checks++; if (ack_a !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || mem_address !== 16'h1234) begin
            failures++; $display("FAIL wr_after ack_a=%b mw=%b busy=%b addr=%h want=0/0/0/1234", ack_a, mem_write, busy, mem_address); end
        drive_req(1'b0, 1'b0, 16'h1234, 8'h00);
        tick();
        checks++; if (ack_a !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h1234) begin
            failures++; $display("FAIL rd_ack ack_a=%b mr=%b mw=%b addr=%h want=1/1/0/1234", ack_a, mem_read, mem_write, mem_address); end
        drop_reqs();
        tick();
        checks++; if (rsp_valid_a !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL rd_wait rsp=%b mr=%b busy=%b want=0/0/1", rsp_valid_a, mem_read, busy); end
        tick();
        checks++; if (rsp_valid_a !== 1'b1 || rsp_valid_b !== 1'b0 || rdata_a !== 8'hA5 || perr_a !== 1'b0) begin
            failures++; $display("FAIL rd_rsp v=%b vb=%b data=%h perr=%b want=1/0/a5/0", rsp_valid_a, rsp_valid_b, rdata_a, perr_a); end
        checks++; if (err_count !== 8'h0) begin
            failures++; $display("FAIL rd_err_count got=%0d want=0", err_count); end
        $display("txn A R addr=1234 data=%h", rdata_a);
        model_last = 1'b0;
        tick();
        checks++; if (rsp_valid_a !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rd_done rsp=%b busy=%b want=0/0", rsp_valid_a, busy); end
    endtask

    task automatic test_round_robin;
        int n = 0;
        int ka = 0, kb = 0;
        logic [3:0] order = '0;
        reset = 1'b1;
        drive_req(1'b0, 1'b1, 16'h2000, 8'($urandom));
        drive_req(1'b1, 1'b1, 16'h3000, 8'($urandom));
        repeat (2) tick();
        reset = 1'b0; model_last = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (ack_a && ack_b) begin
                checks++; failures++; $display("FAIL rr_both_ack ack_a=1 ack_b=1 want=one");
            end else if (ack_a || ack_b) begin
                bit got = ack_b;
                bit exp = pick_b(1'b1, 1'b1, model_last);
                checks++; if (got !== exp) begin
                    failures++; $display("FAIL rr_grant got=%s want=%s", got ? "B" : "A", exp ? "B" : "A"); end
                order[n] = got;
                model_last = got;
                if (!got) begin
                    ref_mem[int'(addr_a)] = wdata_a;
                    $display("txn A W addr=%h data=%h", addr_a, wdata_a);
                    ka++; drive_req(1'b0, 1'b1, 16'h2000 + 16'(ka), 8'($urandom));
                end else begin
                    ref_mem[int'(addr_b)] = wdata_b;
                    $display("txn B W addr=%h data=%h", addr_b, wdata_b);
                    kb++; drive_req(1'b1, 1'b1, 16'h3000 + 16'(kb), 8'($urandom));
                end
                n++;
                if (n == 4) drop_reqs();
            end
        end
        drop_reqs();
        checks++; if (n != 4 || order !== 4'b1010) begin
            failures++; $display("FAIL rr_order acks=%0d order=%b want=4/1010", n, order); end
        tick();
    endtask

    task automatic test_parity;
        logic [7:0] rd; bit pe, oth, ok;
        force_en = 1'b1; force_addr = 16'h0010; force_val = 9'h1A5;
        for (int k = 0; k < 5; k++) begin
            drive_req(1'b0, 1'b0, 16'h0010, 8'h00);
            wait_ack(1'b0, ok);
            drop_reqs();
            checks++; if (!ok) begin failures++; $display("FAIL par_ack_timeout got=none want=ack_a"); end
            model_last = 1'b0;
            wait_rsp(1'b0, rd, pe, oth, ok);
            checks++; if (!ok || rd !== 8'hA5 || pe !== 1'b1) begin
                failures++; $display("FAIL par_rsp ok=%b data=%h perr=%b want=1/a5/1", ok, rd, pe); end
            checks++; if (err_count !== 8'(k + 1) || d2_err_count !== 2'((k + 1 > 3) ? 3 : k + 1)) begin
                failures++; $display("FAIL par_err_count got=%0d/%0d want=%0d/%0d", err_count, d2_err_count, k + 1, (k + 1 > 3) ? 3 : k + 1); end
            $display("txn A R addr=0010 data=%h perr=%b err=%0d", rd, pe, err_count);
        end
        force_en = 1'b0;
    endtask

    task automatic test_random_readback;
        logic [15:0] addrs [6];
        int idx [6];
        logic [7:0] rd; bit pe, oth, ok;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            do a = 16'($urandom_range(16'h5000, 16'hEFFF)); while (ref_mem.exists(int'(a)));
            addrs[i] = a; idx[i] = i;
            drive_req(1'b0, 1'b1, a, 8'($urandom));
            ref_mem[int'(a)] = wdata_a;
            wait_ack(1'b0, ok);
            drop_reqs();
            checks++; if (!ok) begin failures++; $display("FAIL rb_wr_timeout got=none want=ack_a"); end
            model_last = 1'b0;
            $display("txn A W addr=%h data=%h", a, ref_mem[int'(a)]);
        end
        for (int i = 5; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a = addrs[idx[i]];
            drive_req(1'b1, 1'b0, a, 8'h00);
            wait_ack(1'b1, ok);
            drop_reqs();
            checks++; if (!ok) begin failures++; $display("FAIL rb_rd_timeout got=none want=ack_b"); end
            model_last = 1'b1;
            wait_rsp(1'b1, rd, pe, oth, ok);
            checks++; if (!ok || rd !== ref_mem[int'(a)] || pe !== 1'b0 || oth !== 1'b0) begin
                failures++; $display("FAIL rb_rsp addr=%h ok=%b data=%h perr=%b va=%b want=1/%h/0/0", a, ok, rd, pe, oth, ref_mem[int'(a)]); end
            $display("txn B R addr=%h data=%h", a, rd);
        end
    endtask

    task automatic test_mixed_random;
        logic [7:0] rd; bit pe, oth, ok;
        for (int it = 0; it < 24; it++) begin
            bit ra = 1'($urandom), rb = 1'($urandom);
            bit wa = 1'($urandom), wb = 1'($urandom);
            logic [15:0] aa = 16'h0100 + 16'($urandom_range(0, 7));
            logic [15:0] ab = 16'h0100 + 16'($urandom_range(0, 7));
            bit exp, got, gwe; logic [15:0] ga; logic [7:0] gd;
            int who = -1;
            if (!ra && !rb) ra = 1'b1;
            if (ra) drive_req(1'b0, wa, aa, 8'($urandom));
            if (rb) drive_req(1'b1, wb, ab, 8'($urandom));
            exp = pick_b(ra, rb, model_last);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (ack_a && ack_b) begin who = 2; break; end
                if (ack_a) begin who = 0; break; end
                if (ack_b) begin who = 1; break; end
            end
            got = (who == 1);
            gwe = got ? we_b : we_a; ga = got ? addr_b : addr_a; gd = got ? wdata_b : wdata_a;
            drop_reqs();
            checks++; if (who < 0 || who == 2 || got !== exp) begin
                failures++; $display("FAIL mix_grant it=%0d ack=%0d want=%s", it, who, exp ? "B" : "A"); end
            model_last = exp;
            if (gwe) begin
                ref_mem[int'(ga)] = gd;
                $display("txn %s W addr=%h data=%h", got ? "B" : "A", ga, gd);
            end else begin
                logic [7:0] want = ref_mem.exists(int'(ga)) ? ref_mem[int'(ga)] : 8'h00;
                wait_rsp(got, rd, pe, oth, ok);
                checks++; if (!ok || rd !== want || pe !== 1'b0 || oth !== 1'b0) begin
                    failures++; $display("FAIL mix_rsp it=%0d ok=%b data=%h perr=%b other=%b want=1/%h/0/0", it, ok, rd, pe, oth, want); end
                $display("txn %s R addr=%h data=%h", got ? "B" : "A", ga, rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rd; bit pe, oth, ok;
        bit saw_rsp = 1'b0;
        drive_req(1'b1, 1'b0, 16'h1234, 8'h00);
        wait_ack(1'b1, ok);
        drop_reqs();
        checks++; if (!ok) begin failures++; $display("FAIL rm_ack_timeout got=none want=ack_b"); end
        tick();                         // now in the wait-for-data cycle
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid_b !== 1'b0 || err_count !== 8'h0 || mem_address !== 16'h0) begin
            failures++; $display("FAIL rm_reset busy=%b rsp=%b err=%0d addr=%h want=0/0/0/0000", busy, rsp_valid_b, err_count, mem_address); end
        reset = 1'b0; model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid_a || rsp_valid_b) saw_rsp = 1'b1;
        end
        checks++; if (saw_rsp !== 1'b0) begin
            failures++; $display("FAIL rm_no_rsp got=1 want=0"); end
        $display("txn B R addr=1234 aborted by reset");
        drive_req(1'b1, 1'b1, 16'h4444, 8'h3C);
        tick();
        checks++; if (ack_b !== 1'b1 || mem_write !== 1'b1 || mem_address !== 16'h4444 || mem_data_in !== 8'h3C) begin
            failures++; $display("FAIL rm_wr ack_b=%b mw=%b addr=%h data=%h want=1/1/4444/3c", ack_b, mem_write, mem_address, mem_data_in); end
        ref_mem[16'h4444] = 8'h3C; model_last = 1'b1;
        $display("txn B W addr=4444 data=3c");
        drop_reqs();
        tick();
        drive_req(1'b0, 1'b0, 16'h4444, 8'h00);
        wait_ack(1'b0, ok);
        drop_reqs();
        model_last = 1'b0;
        wait_rsp(1'b0, rd, pe, oth, ok);
        checks++; if (!ok || rd !== 8'h3C || pe !== 1'b0) begin
            failures++; $display("FAIL rm_readback ok=%b data=%h perr=%b want=1/3c/0", ok, rd, pe); end
        $display("txn A R addr=4444 data=%h", rd);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_parity();
        test_random_readback();
        test_mixed_random();
        test_reset_mid();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
